// File: rtl/pixel_pkg.sv
// Shared frame geometry, coordinate/state types and the pixel-to-word address map
// used by the pixel_cache responder.
package pixel_pkg;

  localparam int unsigned FRAME_W       = 640;
  localparam int unsigned FRAME_H       = 480;
  localparam int unsigned WORDS_PER_ROW = FRAME_W / 32;
  localparam int unsigned ADDR_W        = 14;
  localparam int unsigned WORD_W        = 32;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_FETCH,
    ST_RESPOND
  } pc_state_t;

  // Row-major word address: 32 pixels per word, bit 0 is the leftmost pixel.
  function automatic logic [ADDR_W-1:0] word_addr(input coord_t x, input coord_t y);
    return ADDR_W'(y * WORDS_PER_ROW) + ADDR_W'(x[9:5]);
  endfunction

endpackage

// File: rtl/pixel_cache_tags.sv
// Direct-mapped line store: valid/tag/data arrays with one combinational
// read-compare port and one fill port; flush clears every valid bit.
module pixel_cache_tags #(
  parameter int unsigned LINES = 8,
  parameter int unsigned IDX_W = $clog2(LINES),
  parameter int unsigned TAG_W = 14 - IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             hit_c,
  output logic [31:0]      rd_data_c,
  input  logic             fill_en,
  input  logic [IDX_W-1:0] fill_index,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [31:0]      fill_data
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // A fill in the same cycle as a flush still lands valid: the word is new-frame data.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (flush)   valid_q <= '0;
      if (fill_en) valid_q[fill_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= fill_data;
    end
  end

  assign hit_c     = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
  assign rd_data_c = data_q[rd_index];

endmodule

// File: rtl/pixel_cache.sv
// Pixel-read responder: returns one bit of a binary frame held in 32-bit word
// memory, fronted by a small direct-mapped word cache.
module pixel_cache #(
  parameter int unsigned FRAME_W = 640,
  parameter int unsigned FRAME_H = 480,
  parameter int unsigned LINES   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        request,
  output logic        pixel,
  output logic        ready,
  input  logic        flush,
  output logic [13:0] mem_addr,
  output logic        mem_req,
  input  logic [31:0] mem_data,
  input  logic        mem_valid
);

  import pixel_pkg::*;

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;

  pc_state_t         state_q, state_d;
  coord_t            xq, yq;
  logic [ADDR_W-1:0] addr_c;
  logic              oor_c, hit_c, fill_en_c;
  logic [31:0]       rd_data_c;
  logic              pixel_d, ready_d, mem_req_d;
  logic [13:0]       mem_addr_d;

  assign addr_c    = word_addr(xq, yq);
  assign oor_c     = (32'(xq) >= FRAME_W) || (32'(yq) >= FRAME_H);
  assign fill_en_c = (state_q == ST_FETCH) && mem_valid && !reset;

  pixel_cache_tags #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_tags (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .rd_index   (addr_c[IDX_W-1:0]),
    .rd_tag     (addr_c[ADDR_W-1:IDX_W]),
    .hit_c      (hit_c),
    .rd_data_c  (rd_data_c),
    .fill_en    (fill_en_c),
    .fill_index (addr_c[IDX_W-1:0]),
    .fill_tag   (addr_c[ADDR_W-1:IDX_W]),
    .fill_data  (mem_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (request) state_d = ST_LOOKUP;
      ST_LOOKUP:  state_d = (oor_c || hit_c) ? ST_RESPOND : ST_FETCH;
      ST_FETCH:   if (mem_valid) state_d = ST_RESPOND;
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs; pixel and mem_addr hold between uses.
  always_comb begin
    pixel_d    = pixel;
    ready_d    = 1'b0;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr;
    case (state_q)
      ST_LOOKUP: begin
        if (oor_c) begin
          pixel_d = 1'b0;
          ready_d = 1'b1;
        end else if (hit_c) begin
          pixel_d = rd_data_c[xq[4:0]];
          ready_d = 1'b1;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = addr_c;
        end
      end
      ST_FETCH: begin
        if (mem_valid) begin
          pixel_d = mem_data[xq[4:0]];
          ready_d = 1'b1;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel    <= 1'b0;
      ready    <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      xq       <= '0;
      yq       <= '0;
    end else begin
      pixel    <= pixel_d;
      ready    <= ready_d;
      mem_req  <= mem_req_d;
      mem_addr <= mem_addr_d;
      if (state_q == ST_IDLE && request) begin
        xq <= x;
        yq <= y;
      end
    end
  end

endmodule

// File: tb/tb_pixel_cache.sv
// Randomized scoreboard bench for pixel_cache with a word-level frame model and
// an abstract direct-mapped cache occupancy model.
module tb_pixel_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        request = 1'b0;
  logic        pixel;
  logic        ready;
  logic        flush = 1'b0;
  logic [13:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_data = '0;
  logic        mem_valid = 1'b0;

  pixel_cache dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .request   (request),
    .pixel     (pixel),
    .ready     (ready),
    .flush     (flush),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_data  (mem_data),
    .mem_valid (mem_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit pix;
    int kind;   // 0 hit, 1 miss, 2 out of range
    int addr;
    int c0;
    int fetch0;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] frame_mem [9600];
  bit          m_valid [8];
  int          m_tag   [8];
  int          checks = 0;
  int          errors = 0;
  int          unexp = 0;
  int          fetches = 0;
  int          last_addr = -1;
  int          valid_cyc = 0;
  int          mem_delay = -1;
  bit          auto_mem = 1'b1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_fill(input int addr);
    m_valid[addr % 8] = 1'b1;
    m_tag[addr % 8]   = addr / 8;
  endtask

  // Issue one request (called at posedge+1), push expectation, hold until ready.
  task automatic issue(input int px, input int py, input bit fl);
    exp_t e;
    bit   done;
    int   addr;
    if (fl) model_clear();
    addr     = py * 20 + px / 32;
    e.addr   = addr;
    e.c0     = cyc;
    e.fetch0 = fetches;
    if (px >= 640 || py >= 480) begin
      e.kind = 2;
      e.pix  = 1'b0;
    end else begin
      e.pix = frame_mem[addr][px % 32];
      if (m_valid[addr % 8] && m_tag[addr % 8] == addr / 8) e.kind = 0;
      else begin
        e.kind = 1;
        model_fill(addr);
      end
    end
    exp_q.push_back(e);
    x = 10'(px);
    y = 10'(py);
    request = 1'b1;
    if (fl) flush = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (ready) done = 1'b1;
      @(posedge clk); #1;
      if (fl) flush = 1'b0;
    end
    request = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL req_timeout x=%0d y=%0d no ready within 40 cycles", px, py);
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    model_clear();
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // Memory model: answers mem_req after a chosen or random delay.
  task automatic responder();
    int d;
    forever begin
      @(posedge clk); #1;
      if (auto_mem && mem_req) begin
        d = (mem_delay < 0) ? int'($urandom_range(0, 5)) : mem_delay;
        repeat (d) begin @(posedge clk); #1; end
        mem_data  = frame_mem[mem_addr];
        mem_valid = 1'b1;
        last_addr = int'(mem_addr);
        valid_cyc = cyc;
        fetches++;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        mem_data  = $urandom;
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          unexp++;
          $display("FAIL unexpected_ready at cyc %0d with no request outstanding", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("pixel", int'(pixel), int'(e.pix));
          if (e.kind == 1) begin
            chk("miss_fetch_count", fetches, e.fetch0 + 1);
            chk("miss_fetch_addr", last_addr, e.addr);
            chk("miss_latency", cyc, valid_cyc + 1);
          end else begin
            chk("hit_oor_no_fetch", fetches, e.fetch0);
            chk("hit_oor_latency", cyc - e.c0, 2);
          end
        end
      end
    end
  endtask

  initial begin
    int px, py;
    for (int i = 0; i < 9600; i++) frame_mem[i] = $urandom;
    frame_mem[41] = 32'h0000_0020;
    model_clear();
    fork
      responder();
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pixel", int'(pixel), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_mem_req", int'(mem_req), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Cold miss, then hit on the same word
    mem_delay = 4;
    issue(37, 2, 1'b0);
    mem_delay = -1;
    issue(33, 2, 1'b0);

    // Conflict eviction on index 0
    issue(0, 0, 1'b0);
    issue(0, 1, 1'b0);
    issue(0, 12, 1'b0);
    issue(0, 0, 1'b0);

    // Out of range
    issue(640, 0, 1'b0);
    issue(0, 480, 1'b0);
    issue(1023, 1023, 1'b0);

    // Flush in idle forces a refetch
    issue(0, 0, 1'b0);
    do_flush();
    issue(0, 0, 1'b0);

    // Flush during FETCH: fill still completes and is usable
    mem_delay = 3;
    fork
      issue(0, 1, 1'b0);
      begin
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        @(posedge clk); #1;
        flush = 1'b1;
        model_clear();
        model_fill(20);
        @(posedge clk); #1;
        flush = 1'b0;
      end
    join
    mem_delay = -1;
    issue(0, 1, 1'b0);

    // Flush together with a request: lookup sees an empty cache
    issue(0, 1, 1'b1);

    // Reset while a fetch is outstanding
    auto_mem = 1'b0;
    x = 10'd5;
    y = 10'd3;
    request = 1'b1;
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    chk("rst_fetch_req", int'(mem_req), 1);
    chk("rst_fetch_addr", int'(mem_addr), 60);
    @(posedge clk); #1;
    request = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_drops_mem_req", int'(mem_req), 0);
    reset = 1'b0;
    model_clear();
    mem_data  = 32'hFFFF_FFFF;
    mem_valid = 1'b1;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("no_stray_ready", unexp, 0);
    auto_mem = 1'b1;
    issue(5, 3, 1'b0);

    // Randomized traffic over a small window so hits, misses and conflicts mix
    for (int n = 0; n < 250; n++) begin
      px = ($urandom_range(0, 15) == 0) ? int'($urandom_range(600, 1023)) : int'($urandom_range(0, 127));
      py = ($urandom_range(0, 15) == 0) ? int'($urandom_range(470, 1023)) : int'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) do_flush();
      issue(px, py, ($urandom_range(0, 19) == 0));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
